// File: rtl/vram_arb_pkg.sv
// ============================================================================
// vram_arb_pkg : shared owner encodings and default widths for vram_arb
// Rev 1.0
// ============================================================================
`default_nettype none

package vram_arb_pkg;

   localparam int DEF_ADDRW = 14;
   localparam int DEF_DATAW = 16;

   typedef logic [1:0] owner_t;

   localparam owner_t OWN_NONE = 2'd0;
   localparam owner_t OWN_DISP = 2'd1;
   localparam owner_t OWN_DRAW = 2'd2;

   // Tag for the read-return pipeline; writes carry no tag.
   function automatic owner_t own_of(input logic disp_g, input logic draw_g, input logic draw_w);
      if (disp_g)
         return OWN_DISP;
      else if (draw_g && !draw_w)
         return OWN_DRAW;
      return OWN_NONE;
   endfunction

endpackage

`default_nettype wire

// File: rtl/vram_arb_stats.sv
// ============================================================================
// vram_arb_stats : transfer and draw-stall counters for vram_arb
// Rev 1.0
// ============================================================================
`default_nettype none

module vram_arb_stats (
   input  logic        clk,
   input  logic        rst,
   input  logic        stat_clr,
   input  logic        disp_xfer,
   input  logic        draw_xfer,
   input  logic        draw_stall,
   output logic [31:0] stat_disp_cnt,
   output logic [31:0] stat_draw_cnt,
   output logic [31:0] stat_stall_cnt
);

   logic [31:0] r_disp_cnt;
   logic [31:0] r_draw_cnt;
   logic [31:0] r_stall_cnt;

   // Clear wins over a same-cycle increment; counters wrap naturally.
   always_ff @(posedge clk) begin
      if (!rst || stat_clr) begin
         r_disp_cnt  <= '0;
         r_draw_cnt  <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (disp_xfer)
            r_disp_cnt <= r_disp_cnt + 32'd1;
         if (draw_xfer)
            r_draw_cnt <= r_draw_cnt + 32'd1;
         if (draw_stall)
            r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stat_disp_cnt  = r_disp_cnt;
   assign stat_draw_cnt  = r_draw_cnt;
   assign stat_stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: rtl/vram_arb.sv
// ============================================================================
// vram_arb : display/draw arbiter for a single-port synchronous VRAM
// Optional statistics counters under VRAM_ARB_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module vram_arb
   import vram_arb_pkg::*;
#(
   parameter int ADDRW      = DEF_ADDRW,
   parameter int DATAW      = DEF_DATAW,
   parameter int STARVE_LIM = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             disp_req,
   input  logic             disp_urgent,
   input  logic [ADDRW-1:0] disp_addr,
   output logic             disp_gnt,
   output logic             disp_rvalid,
   output logic [DATAW-1:0] disp_rdata,
   input  logic             draw_req,
   input  logic             draw_we,
   input  logic [ADDRW-1:0] draw_addr,
   input  logic [DATAW-1:0] draw_wdata,
   output logic             draw_gnt,
   output logic             draw_rvalid,
   output logic [DATAW-1:0] draw_rdata,
   output logic             mem_en,
   output logic             mem_we,
   output logic [ADDRW-1:0] mem_addr,
   output logic [DATAW-1:0] mem_wdata,
   input  logic [DATAW-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
   ,
   input  logic             stat_clr,
   output logic [31:0]      stat_disp_cnt,
   output logic [31:0]      stat_draw_cnt,
   output logic [31:0]      stat_stall_cnt
`endif
);

   localparam logic [7:0] c_starve_lim = 8'(STARVE_LIM);

   logic             w_disp_gnt;
   logic             w_draw_gnt;
   logic [7:0]       r_starve_cnt;
   logic             r_mem_en;
   logic             r_mem_we;
   logic [ADDRW-1:0] r_mem_addr;
   logic [DATAW-1:0] r_mem_wdata;
   owner_t           r_own_s1;
   owner_t           r_own_s2;

   always_comb begin
      w_disp_gnt = 1'b0;
      w_draw_gnt = 1'b0;
      if (rst) begin
         if (disp_req && draw_req) begin
            if (disp_urgent || (r_starve_cnt < c_starve_lim))
               w_disp_gnt = 1'b1;
            else
               w_draw_gnt = 1'b1;
         end else begin
            w_disp_gnt = disp_req;
            w_draw_gnt = draw_req;
         end
      end
   end

   assign disp_gnt = w_disp_gnt;
   assign draw_gnt = w_draw_gnt;

   // Counts disp wins only while draw is actually waiting.
   always_ff @(posedge clk) begin
      if (!rst)
         r_starve_cnt <= '0;
      else if (w_draw_gnt || !draw_req)
         r_starve_cnt <= '0;
      else if (w_disp_gnt && (r_starve_cnt < c_starve_lim))
         r_starve_cnt <= r_starve_cnt + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else if (w_disp_gnt) begin
         r_mem_en    <= 1'b1;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= disp_addr;
      end else if (w_draw_gnt) begin
         r_mem_en    <= 1'b1;
         r_mem_we    <= draw_we;
         r_mem_addr  <= draw_addr;
         r_mem_wdata <= draw_wdata;
      end else begin
         r_mem_en    <= 1'b0;
      end
   end

   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

   // Stage 1 aligns with the RAM access, stage 2 with the returned data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_own_s1 <= OWN_NONE;
         r_own_s2 <= OWN_NONE;
      end else begin
         r_own_s1 <= own_of(w_disp_gnt, w_draw_gnt, draw_we);
         r_own_s2 <= r_own_s1;
      end
   end

   assign disp_rvalid = (r_own_s2 == OWN_DISP);
   assign draw_rvalid = (r_own_s2 == OWN_DRAW);
   assign disp_rdata  = mem_rdata;
   assign draw_rdata  = mem_rdata;

`ifdef VRAM_ARB_STATS_EN
   logic w_draw_stall;

   assign w_draw_stall = draw_req && !w_draw_gnt;

   vram_arb_stats u_stats (
      .clk            (clk),
      .rst            (rst),
      .stat_clr       (stat_clr),
      .disp_xfer      (w_disp_gnt),
      .draw_xfer      (w_draw_gnt),
      .draw_stall     (w_draw_stall),
      .stat_disp_cnt  (stat_disp_cnt),
      .stat_draw_cnt  (stat_draw_cnt),
      .stat_stall_cnt (stat_stall_cnt)
   );
`endif

endmodule

`default_nettype wire

// File: tb/tb_vram_arb.sv
// ============================================================================
// tb_vram_arb : directed self-checking bench for vram_arb with read scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vram_arb;
   import vram_arb_pkg::*;

   localparam int ADDRW = 14;
   localparam int DATAW = 16;
   localparam int LIM   = 8;
   localparam int DEPTH = 1 << ADDRW;

   logic             clk = 1'b0;
   logic             rst;
   logic             disp_req, disp_urgent, disp_gnt, disp_rvalid;
   logic [ADDRW-1:0] disp_addr;
   logic [DATAW-1:0] disp_rdata;
   logic             draw_req, draw_we, draw_gnt, draw_rvalid;
   logic [ADDRW-1:0] draw_addr;
   logic [DATAW-1:0] draw_wdata, draw_rdata;
   logic             mem_en, mem_we;
   logic [ADDRW-1:0] mem_addr;
   logic [DATAW-1:0] mem_wdata;
   logic [DATAW-1:0] mem_rdata;

   always #5 clk = ~clk;

   vram_arb #(.ADDRW(ADDRW), .DATAW(DATAW), .STARVE_LIM(LIM)) dut (
      .clk         (clk),
      .rst         (rst),
      .disp_req    (disp_req),
      .disp_urgent (disp_urgent),
      .disp_addr   (disp_addr),
      .disp_gnt    (disp_gnt),
      .disp_rvalid (disp_rvalid),
      .disp_rdata  (disp_rdata),
      .draw_req    (draw_req),
      .draw_we     (draw_we),
      .draw_addr   (draw_addr),
      .draw_wdata  (draw_wdata),
      .draw_gnt    (draw_gnt),
      .draw_rvalid (draw_rvalid),
      .draw_rdata  (draw_rdata),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   // VRAM model: one-cycle read latency.
   logic [DATAW-1:0] ram [0:DEPTH-1];

   initial begin
      for (int i = 0; i < DEPTH; i++)
         ram[i] <= 16'(i) ^ 16'hA5C3;
      ram[16'h0010] <= 16'hBEEF;
   end

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we)
            ram[mem_addr] <= mem_wdata;
         else
            mem_rdata <= ram[mem_addr];
      end
   end

   typedef struct {
      owner_t           own;
      logic [DATAW-1:0] data;
      int               due;
   } rd_t;

   logic [DATAW-1:0] shadow [0:DEPTH-1];
   rd_t              sbq[$];
   int               cyc;
   int               total;
   int               bad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Sample mid-cycle: retire due reads, then log this cycle's transfers.
   task automatic samp();
      rd_t e;
      @(negedge clk);
      cyc++;
      chk("one_gnt", 32'(disp_gnt & draw_gnt), 32'd0);
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         e = sbq.pop_front();
         chk("rv_disp", 32'(disp_rvalid), 32'(e.own == OWN_DISP));
         chk("rv_draw", 32'(draw_rvalid), 32'(e.own == OWN_DRAW));
         chk("rdata", 32'((e.own == OWN_DISP) ? disp_rdata : draw_rdata), 32'(e.data));
      end else begin
         chk("rv_idle", 32'({disp_rvalid, draw_rvalid}), 32'd0);
      end
      if (disp_gnt === 1'b1)
         sbq.push_back('{OWN_DISP, shadow[disp_addr], cyc + 2});
      if (draw_gnt === 1'b1) begin
         if (draw_we)
            shadow[draw_addr] = draw_wdata;
         else
            sbq.push_back('{OWN_DRAW, shadow[draw_addr], cyc + 2});
      end
   endtask

   task automatic idle(input int n);
      disp_req = 1'b0;
      draw_req = 1'b0;
      disp_urgent = 1'b0;
      repeat (n) begin
         samp();
         nxt();
      end
   endtask

   int nd;

   initial begin
      total = 0; bad = 0; cyc = 0;
      for (int i = 0; i < DEPTH; i++)
         shadow[i] = 16'(i) ^ 16'hA5C3;
      shadow[16'h0010] = 16'hBEEF;

      rst = 1'b0;
      disp_req = 1'b1; disp_urgent = 1'b0; disp_addr = 14'h0055;
      draw_req = 1'b1; draw_we = 1'b1; draw_addr = 14'h0066; draw_wdata = 16'h7777;

      // Reset held with both requesters active.
      repeat (3) begin
         samp();
         chk("rst_dgnt", 32'(disp_gnt), 32'd0);
         chk("rst_wgnt", 32'(draw_gnt), 32'd0);
         chk("rst_en", 32'(mem_en), 32'd0);
         chk("rst_we", 32'(mem_we), 32'd0);
         chk("rst_addr", 32'(mem_addr), 32'd0);
         chk("rst_wdata", 32'(mem_wdata), 32'd0);
         nxt();
      end
      rst = 1'b1;
      draw_we = 1'b0;
      idle(1);

      // Single display read.
      disp_req = 1'b1; disp_addr = 14'h0010;
      samp();
      chk("d1_gnt", 32'(disp_gnt), 32'd1);
      chk("d1_wgnt", 32'(draw_gnt), 32'd0);
      nxt();
      disp_req = 1'b0;
      samp();
      chk("d1_en", 32'(mem_en), 32'd1);
      chk("d1_we", 32'(mem_we), 32'd0);
      chk("d1_addr", 32'(mem_addr), 32'h0010);
      nxt();
      samp();
      chk("d1_rv", 32'(disp_rvalid), 32'd1);
      chk("d1_rd", 32'(disp_rdata), 32'hBEEF);
      chk("d1_wrv", 32'(draw_rvalid), 32'd0);
      nxt();
      samp();
      chk("d1_en_off", 32'(mem_en), 32'd0);
      chk("d1_addr_hold", 32'(mem_addr), 32'h0010);
      nxt();

      // Contention: 8 disp grants then one draw grant, repeating.
      nd = 0;
      disp_req = 1'b1; disp_addr = 14'h0100;
      draw_req = 1'b1; draw_we = 1'b0; draw_addr = 14'h0300;
      for (int i = 0; i < 27; i++) begin
         samp();
         chk("ct_dgnt", 32'(disp_gnt), 32'((i % 9) != 8));
         chk("ct_wgnt", 32'(draw_gnt), 32'((i % 9) == 8));
         if (disp_gnt === 1'b1)
            nd++;
         nxt();
         disp_addr = 14'(14'h0100 + nd);
      end
      idle(3);
      chk("ct_drain", 32'(sbq.size()), 32'd0);

      // Urgency overrides the starvation limit.
      disp_req = 1'b1; disp_urgent = 1'b1; disp_addr = 14'h0020;
      draw_req = 1'b1; draw_addr = 14'h0301;
      repeat (12) begin
         samp();
         chk("ur_dgnt", 32'(disp_gnt), 32'd1);
         chk("ur_wgnt", 32'(draw_gnt), 32'd0);
         nxt();
      end
      disp_urgent = 1'b0;
      samp();
      chk("ur_rel_w", 32'(draw_gnt), 32'd1);
      nxt();
      draw_addr = 14'h0302;
      samp();
      chk("ur_rel_d", 32'(disp_gnt), 32'd1);
      nxt();
      idle(3);

      // Draw write then read of the same address.
      draw_req = 1'b1; draw_we = 1'b1; draw_addr = 14'h0200; draw_wdata = 16'h1234;
      samp();
      chk("wr_gnt", 32'(draw_gnt), 32'd1);
      nxt();
      draw_we = 1'b0; draw_wdata = 16'h0000;
      samp();
      chk("rd_gnt", 32'(draw_gnt), 32'd1);
      chk("wr_en", 32'(mem_en), 32'd1);
      chk("wr_we", 32'(mem_we), 32'd1);
      chk("wr_addr", 32'(mem_addr), 32'h0200);
      chk("wr_wdata", 32'(mem_wdata), 32'h1234);
      nxt();
      draw_req = 1'b0;
      samp();
      chk("rd_we", 32'(mem_we), 32'd0);
      chk("rd_en", 32'(mem_en), 32'd1);
      chk("wr_norv", 32'(draw_rvalid), 32'd0);
      nxt();
      samp();
      chk("rd_rv", 32'(draw_rvalid), 32'd1);
      chk("rd_data", 32'(draw_rdata), 32'h1234);
      nxt();
      idle(2);

      // Reset during in-flight display reads.
      disp_req = 1'b1; disp_addr = 14'h0040;
      draw_req = 1'b1; draw_addr = 14'h0303;
      repeat (3) begin
         samp();
         chk("mr_dgnt", 32'(disp_gnt), 32'd1);
         nxt();
         disp_addr = disp_addr + 14'd1;
      end
      rst = 1'b0;
      samp();
      chk("mr_gnt0", 32'({disp_gnt, draw_gnt}), 32'd0);
      sbq.delete();
      nxt();
      samp();
      chk("mr_norv", 32'(disp_rvalid), 32'd0);
      nxt();
      rst = 1'b1;
      for (int i = 0; i < 9; i++) begin
         samp();
         chk("mr_dgnt2", 32'(disp_gnt), 32'(i != 8));
         chk("mr_wgnt2", 32'(draw_gnt), 32'(i == 8));
         nxt();
      end
      idle(3);
      chk("sb_empty", 32'(sbq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/vram_arb.md
Name: vram_arb

Overview:
- Arbitrates one single-port synchronous video RAM between two requesters:
  - display scanout line-fetch (disp), high priority;
  - drawing engine (draw), low priority.
- Sits between the chapter display pipeline and the VRAM macro.
- Issues one registered memory access per cycle and routes read data back to its owner.
- Prevents draw starvation with a bounded-wait counter, unless the display signals urgency.

Parameters:
- ADDRW, 14, VRAM address width (bits).
- DATAW, 16, VRAM data width (bits).
- STARVE_LIM, 8, maximum consecutive disp grants while draw waits (1..255).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low (asserted when 0).
- disp_req  input  1  display read request.
- disp_urgent  input  1  display line buffer near empty; overrides anti-starvation.
- disp_addr  input  ADDRW  display read address.
- disp_gnt  output  1  disp request accepted this cycle.
- disp_rvalid  output  1  disp read data valid.
- disp_rdata  output  DATAW  disp read data.
- draw_req  input  1  draw request.
- draw_we  input  1  draw write enable (0 = read).
- draw_addr  input  ADDRW  draw address.
- draw_wdata  input  DATAW  draw write data.
- draw_gnt  output  1  draw request accepted this cycle.
- draw_rvalid  output  1  draw read data valid.
- draw_rdata  output  DATAW  draw read data.
- mem_en  output  1  VRAM access enable (registered).
- mem_we  output  1  VRAM write enable (registered).
- mem_addr  output  ADDRW  VRAM address (registered).
- mem_wdata  output  DATAW  VRAM write data (registered).
- mem_rdata  input  DATAW  VRAM read data, valid 1 cycle after mem_en with mem_we=0.

Behaviour:
- Transfer: X_req && X_gnt in cycle T.
- Grants are combinational from current requests and state.
- At most one grant per cycle.
- A requester holds req/addr/we/wdata stable until granted.
- Grant rule, evaluated each cycle:
  - neither requesting: no grant;
  - one requesting: grant it;
  - both requesting and (disp_urgent or starve_cnt < STARVE_LIM): grant disp;
  - both requesting, no urgency, starve_cnt == STARVE_LIM: grant draw.
- starve_cnt (8-bit) update:
  - increments on a disp grant while draw_req=1;
  - clears on a draw grant or whenever draw_req=0;
  - saturates at STARVE_LIM.
- Memory port:
  - transfer at T drives mem_en=1 plus mem_we/mem_addr/mem_wdata at T+1 from the granted source;
  - disp accesses always drive mem_we=0;
  - with no transfer, mem_en=0 and the other mem_* outputs hold their last values.
- Read return:
  - a 2-bit owner pipeline tags each read issued;
  - a read transferred at T gives X_rvalid=1 at T+2 for exactly one cycle, with X_rdata=mem_rdata combinationally;
  - writes produce no rvalid;
  - both rdata outputs always carry mem_rdata; only the rvalids are steered.
- Throughput: back-to-back transfers every cycle; reads and writes interleave freely with no turnaround.
- Ordering: per-requester read data returns in request order.
- Reset (rst=0 sampled at clk edge):
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - disp_rvalid=0, draw_rvalid=0, starve_cnt=0, owner pipeline cleared;
  - gnt outputs are 0 while rst=0.
- Reset mid-operation: in-flight reads are discarded, with no rvalid after reset. A write already on mem_* at the reset edge is not cancelled; the RAM completes it.

Optional Feature:
- VRAM_ARB_STATS_EN defined:
  - adds outputs stat_disp_cnt[31:0], stat_draw_cnt[31:0], stat_stall_cnt[31:0], plus input stat_clr;
  - counts disp transfers, draw transfers, and cycles with draw_req=1 and draw_gnt=0;
  - counters wrap at 2^32;
  - cleared by reset or stat_clr=1; clear has priority over increment in the same cycle.
- Undefined: the ports and counters are absent; arbitration is identical.

Decomposition:
- Shared constants header: owner encodings OWN_NONE=0, OWN_DISP=1, OWN_DRAW=2 and the default ADDRW/DATAW.
- Optional sub-module vram_arb_stats holds the three counters. It is instantiated only under VRAM_ARB_STATS_EN.
- Grant logic, starvation counter and owner pipeline stay in vram_arb.

Test Plan:
- Reset: hold rst=0 for 3 cycles with both requesters asserting -> all outputs 0, no grants.
- disp only: disp_req at addr 0x0010, mem_rdata=0xBEEF at T+2 -> disp_gnt at T, mem_en/mem_addr=0x0010 at T+1, disp_rvalid=1 with 0xBEEF at T+2, draw_rvalid=0.
- Contention with STARVE_LIM=8: both requesting continuously, urgent=0 -> 8 disp grants, then 1 draw grant, repeating (9-cycle period).
- Urgency: same as previous but disp_urgent=1 throughout -> disp granted every cycle, draw_gnt never asserted, stall counter (if enabled) rises by 1 per cycle.
- Draw write then read: write 0x1234 to 0x0200, next cycle read 0x0200 -> mem_we=1 then 0, draw_rvalid only for the read, at read-transfer+2.
- Reset mid-read: disp read transferred at T, rst=0 at T+1 -> no disp_rvalid at T+2, starve_cnt=0 after release.
